memory_responder: RTL
=====================

// Module: memory_responder
// PURPOSE
//  Memory-side end of the MFA/MFC handshake driven by the control unit.
//  Samples the MAR address, MBR write data, READ_WRITE and WORD_BYTE when MFA is raised.
//  Performs a word or byte read/write on an internal byte-addressed RAM after a fixed wait.
//  Raises MFC and holds it until MFA drops. Sits between the MAR/MBR datapath and storage.
// PARAMETERS
//  DEPTH    256  RAM size in bytes; power of two, >=4
//  LATENCY  2    cycles from MFA sampled high to MFC high; >=1
// PORTS
//  Clk         in   1   system clock; all state changes on posedge
//  Reset_n     in   1   asynchronous, active-low reset
//  MFA         in   1   memory function activate (request), level
//  READ_WRITE  in   1   1=read, 0=write; sampled with MFA
//  WORD_BYTE   in   1   1=32-bit word, 0=byte; sampled with MFA
//  Address     in   32  byte address from MAR; used modulo DEPTH
//  DataIn      in   32  write data from MBR; byte writes use [7:0]
//  DataOut     out  32  read data to MBR; stable until the next read completes
//  MFC         out  1   memory function complete
//  Err         out  1   present only with MEM_ALIGN_CHECK_EN
// BEHAVIOUR
//  Reset (Reset_n=0, any time, including mid-transaction):
//   - state IDLE, MFC=0, DataOut=0, Err=0, counter=0.
//   - RAM contents are not cleared; any pending write is dropped.
//  FSM: IDLE -> WAIT -> DONE -> IDLE
//   IDLE: MFA=1 at posedge -> latch Address, DataIn, READ_WRITE, WORD_BYTE; cnt=LATENCY-1; go WAIT.
//   WAIT: MFA=0 -> abort: IDLE, no RAM/DataOut change, MFC stays 0.
//         cnt!=0 -> cnt--.
//         cnt==0 -> commit access; MFC<=1; go DONE.
//   DONE: MFC held 1 while MFA=1. MFA=0 -> MFC<=0, go IDLE.
//         A new request needs MFA low for >=1 sampled edge.
//  Latency: MFC rises LATENCY posedges after the edge that first samples MFA=1.
//  Inputs are used only when latched; input changes during WAIT/DONE are ignored.
//  Access rules:
//   - Byte order big-endian: word at A = {M[A],M[A+1],M[A+2],M[A+3]}, with A = Address & ~3.
//   - Word access ignores Address[1:0].
//   - Byte read: DataOut = {24'b0, M[Address]}.
//   - Byte write: M[Address] <= DataIn[7:0]; the other bytes are unchanged.
//   - Address wraps modulo DEPTH; no out-of-range error.
//   - DataOut updates on the commit edge for reads only; writes leave DataOut unchanged.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//   - Err port exists.
//   - A word access with Address[1:0]!=0 completes the handshake normally, but RAM and DataOut
//     are unchanged and Err=1 alongside MFC.
//   - Err clears with MFC.
//  Undefined: no Err port; low address bits are silently ignored for word accesses.
// STRUCTURE
//  mem_pkg:
//   - state enum {IDLE, WAIT, DONE}
//   - RW_READ=1, SIZE_WORD=1, BYTES_PER_WORD=4
//  Sub-module mem_byte_ram (DEPTH x 8):
//   - 4 lane write-enables, 4 read lanes, synchronous write, asynchronous read.
//   - memory_responder holds the FSM, latches, lane/enable generation and DataOut register.
// TESTING
//  1 Word write A=0x10, D=0xDEADBEEF, then word read A=0x10 -> DataOut=0xDEADBEEF; MFC 2 cycles after MFA.
//  2 Byte read A=0x11 after test 1 -> DataOut=0x000000AD.
//    Byte write 0x55 @0x13, then word read -> 0xDEADBE55.
//  3 Hold MFA high 5 extra cycles after MFC -> MFC stays 1.
//    Drop MFA -> MFC=0 next edge; MFA re-raised immediately is not accepted until seen low.
//  4 MFA dropped during WAIT on a write of 0x12345678 @0x20 -> MFC never rises; word read @0x20 returns old value.
//  5 Reset_n low mid-WAIT -> MFC=0, DataOut=0 at once.
//    RAM keeps 0xDEADBE55 @0x10; address 0x110 (DEPTH=256) aliases 0x10.
//  6 MEM_ALIGN_CHECK_EN: word write @0x12 -> Err=1 with MFC, RAM unchanged.
//    Without the macro: the same access writes 0x10.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder (MFA/MFC memory side).
// Optional alignment checking is enabled with MEM_ALIGN_CHECK_EN.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic RW_READ        = 1'b1;
   localparam logic SIZE_WORD      = 1'b1;
   localparam int   BYTES_PER_WORD = 4;

   // Big-endian lane select: lane 0 carries the most significant byte.
   function automatic logic [7:0] word_lane(input logic [31:0] w, input int lane);
      return w[31-8*lane -: 8];
   endfunction

endpackage

// File: rtl/memory_responder_if.sv
// MFA/MFC handshake bundle between the control unit (master) and memory (slave).
// Err exists only when MEM_ALIGN_CHECK_EN is defined.
interface memory_responder_if;

   // Handshake: master raises MFA with the request fields valid; the slave raises MFC
   // once the access is done and holds it until it samples MFA low.
   logic        MFA;
   logic        READ_WRITE;
   logic        WORD_BYTE;
   logic [31:0] Address;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        MFC;
`ifdef MEM_ALIGN_CHECK_EN
   logic        Err;

   modport master (
      output MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
      input  DataOut, MFC, Err
   );

   modport slave (
      input  MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
      output DataOut, MFC, Err
   );
`else
   modport master (
      output MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
      input  DataOut, MFC
   );

   modport slave (
      input  MFA, READ_WRITE, WORD_BYTE, Address, DataIn,
      output DataOut, MFC
   );
`endif

endinterface

// File: rtl/mem_byte_ram.sv
// Byte-wide RAM with four independent lanes: synchronous write, asynchronous read.
// Contents have no reset.
module mem_byte_ram
   import mem_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                                   Clk,
   input  logic [BYTES_PER_WORD-1:0]              lane_we,
   input  logic [BYTES_PER_WORD-1:0][ADDR_W-1:0]  lane_addr,
   input  logic [BYTES_PER_WORD-1:0][7:0]         lane_wdata,
   output logic [BYTES_PER_WORD-1:0][7:0]         lane_rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge Clk) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         if (lane_we[i]) begin
            mem[lane_addr[i]] <= lane_wdata[i];
         end
      end
   end

   always_comb begin
      lane_rdata = '0;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         lane_rdata[i] = mem[lane_addr[i]];
      end
   end

endmodule

// File: rtl/memory_responder.sv
// Memory side of the MFA/MFC handshake: latches a request, waits LATENCY cycles, commits.
// Define MEM_ALIGN_CHECK_EN to flag (and suppress) misaligned word accesses on Err.
module memory_responder
   import mem_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic               Clk,
   input  logic               Reset_n,
   memory_responder_if.slave  bus,
   output state_t             dbg_state
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   state_t                                  state_q, state_d;
   logic [CNT_W-1:0]                        cnt_q, cnt_d;
   logic                                    mfc_q, mfc_d;
   logic                                    err_q, err_d;
   logic                                    latch_en;
   logic                                    commit;
   logic                                    access_ok;
   logic [ADDR_W-1:0]                       addr_q;
   logic [31:0]                             wdata_q;
   logic                                    rw_q;
   logic                                    wb_q;
   logic [31:0]                             dout_q;
   logic [BYTES_PER_WORD-1:0]               lane_we;
   logic [BYTES_PER_WORD-1:0][ADDR_W-1:0]   lane_addr;
   logic [BYTES_PER_WORD-1:0][7:0]          lane_wdata;
   logic [BYTES_PER_WORD-1:0][7:0]          lane_rdata;
   logic [31:0]                             rd_word;
   logic                                    unused_addr_hi;

   // Address bits above the RAM size only alias, so they are dropped at the latch.
   assign unused_addr_hi = ^bus.Address[31:ADDR_W];

`ifdef MEM_ALIGN_CHECK_EN
   assign access_ok = !((wb_q == SIZE_WORD) && (addr_q[1:0] != 2'b00));
`else
   assign access_ok = 1'b1;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mfc_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mfc_q   <= mfc_d;
         err_q   <= err_d;
      end
   end

   // An abort in WAIT wins over the commit, so a late MFA drop never touches RAM.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mfc_d    = mfc_q;
      err_d    = err_q;
      latch_en = 1'b0;
      commit   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.MFA) begin
               latch_en = 1'b1;
               cnt_d    = CNT_W'(LATENCY - 1);
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (!bus.MFA) begin
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               commit  = 1'b1;
               mfc_d   = 1'b1;
               err_d   = !access_ok;
               state_d = DONE;
            end
         end
         DONE: begin
            if (!bus.MFA) begin
               mfc_d   = 1'b0;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            mfc_d   = 1'b0;
            err_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Word accesses use four consecutive bytes from the aligned base; bytes use lane 0 only.
   always_comb begin
      lane_we = '0;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         lane_addr[i]  = {addr_q[ADDR_W-1:2], 2'(i)};
         lane_wdata[i] = word_lane(wdata_q, i);
      end
      if (wb_q != SIZE_WORD) begin
         lane_addr[0]  = addr_q;
         lane_wdata[0] = wdata_q[7:0];
      end
      if (commit && access_ok && (rw_q != RW_READ)) begin
         lane_we = (wb_q == SIZE_WORD) ? 4'b1111 : 4'b0001;
      end
   end

   assign rd_word = {lane_rdata[0], lane_rdata[1], lane_rdata[2], lane_rdata[3]};

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rw_q    <= 1'b0;
         wb_q    <= 1'b0;
         dout_q  <= '0;
      end else begin
         if (latch_en) begin
            addr_q  <= bus.Address[ADDR_W-1:0];
            wdata_q <= bus.DataIn;
            rw_q    <= bus.READ_WRITE;
            wb_q    <= bus.WORD_BYTE;
         end
         if (commit && access_ok && (rw_q == RW_READ)) begin
            dout_q <= (wb_q == SIZE_WORD) ? rd_word : {24'b0, lane_rdata[0]};
         end
      end
   end

   mem_byte_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .Clk        (Clk),
      .lane_we    (lane_we),
      .lane_addr  (lane_addr),
      .lane_wdata (lane_wdata),
      .lane_rdata (lane_rdata)
   );

   assign bus.DataOut = dout_q;
   assign bus.MFC     = mfc_q;
`ifdef MEM_ALIGN_CHECK_EN
   assign bus.Err     = err_q;
`endif
   assign dbg_state   = state_q;

endmodule
